branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6, the BTB index width.
REQ-002 SHALL have parameter HISTORY_WIDTH, default 8, the PHT index and GHR width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have ports IF_pc_i (input, 32), IF_btb_hit_i (input, 1), IF_prediction_i (input, 1), IF_bias_i (input, 1) and IF_ghr_data_i (input, HISTORY_WIDTH), the Fetch-stage PC and predictor results captured per fetched instruction.
REQ-006 SHALL have port IF_valid_i, input, 1, meaning the Fetch stage holds a real instruction.
REQ-007 SHALL have ports stall_i (input, 1), the pipeline hold, and flush_i (input, 1), the wrong-path kill, driven by the predictor's flush output.
REQ-008 SHALL have ports EX_is_br_i, EX_is_jal_i, EX_is_jalr_i and EX_br_taken_i (inputs, 1 each) and EX_target_i (input, 32), the Execute-stage decode and resolution.
REQ-009 SHALL have outputs EXMEM_btb_wr_index_o (INDEX_WIDTH), EXMEM_btb_wr_tag_o (32-INDEX_WIDTH-2), EXMEM_btb_wr_target_o (32) and EXMEM_pht_wr_index_o (HISTORY_WIDTH).
REQ-010 SHALL have 1-bit outputs EXMEM_btb_hit_o, EXMEM_br_decision_o, EXMEM_is_jmp_o, EXMEM_prediction_o, EXMEM_bias_o and EXMEM_mispredict_o, plus output EXMEM_ghr_data_o (HISTORY_WIDTH).
REQ-011 SHALL have outputs perf_br_cnt_o (32) and perf_miss_cnt_o (32) only when BRU_PERF_CNT_EN is defined.

Function
REQ-012 SHALL carry the metadata {valid, pc, btb_hit, prediction, bias, ghr} through three register stages: IF/ID, then ID/EX, then EX/MEM.
REQ-013 SHALL register the EX-stage resolution into EX/MEM together with the metadata, giving a fixed latency of 3 clock edges from the IF capture to the EXMEM outputs.
REQ-014 SHALL hold IF/ID and ID/EX when stall_i=1 and flush_i=0, and shall load a bubble (valid=0) into EX/MEM in that cycle.
REQ-015 SHALL, when flush_i=1, load valid=0 into IF/ID, ID/EX and EX/MEM on that edge, with priority over stall_i.
REQ-016 SHALL compute is_jmp = valid & (is_br | is_jal).
REQ-017 SHALL compute br_decision = valid & (is_jal | is_jalr | (is_br & br_taken)); a JALR therefore gives is_jmp=0 and br_decision=1.
REQ-018 SHALL force prediction, btb_hit and br_decision to 0 when the EX/MEM entry is invalid.
REQ-019 SHALL set mispredict = is_jmp ? (prediction XOR br_decision) : br_decision.
REQ-020 SHALL set btb_wr_index = pc[INDEX_WIDTH+1:2], btb_wr_tag = pc[31:INDEX_WIDTH+2], pht_wr_index = pc[HISTORY_WIDTH+1:2] and btb_wr_target = EX_target_i as registered.
REQ-021 SHALL pass bias and ghr through unchanged, so the PHT update uses the IF-time GHR snapshot.
REQ-022 SHALL treat EX inputs as don't-care when the ID/EX entry is invalid.
REQ-023 SHALL let simultaneous is_br and is_jal fall under the is_jmp rule (JAL dominates br_decision), with no error flag.

Reset
REQ-024 SHALL clear every stage valid bit and every registered field to 0 on a clock edge with rst_ni=0, so that all EXMEM outputs read 0 in the following cycle.
REQ-025 SHALL discard in-flight entries when reset is asserted mid-operation, and shall accept a new IF capture on the first edge after rst_ni returns to 1.

Configuration
REQ-026 SHALL, when macro BRU_PERF_CNT_EN is defined, increment perf_br_cnt_o on every valid EX/MEM entry with is_jmp=1 or JALR.
REQ-027 SHALL, under BRU_PERF_CNT_EN, increment perf_miss_cnt_o whenever EXMEM_mispredict_o=1; both counters reset to 0 and wrap 0xFFFFFFFF to 0.
REQ-028 SHALL, when BRU_PERF_CNT_EN is undefined, omit both counters and their ports, with all other behaviour identical.

Verification
REQ-029 SHALL cover: BEQ at PC 0x0000_0040 with pred=1 and taken=1 -> 3 edges later is_jmp=1, decision=1, mispredict=0, btb_wr_index=0x10, pht_wr_index=0x10.
REQ-030 SHALL cover: BNE with pred=0, taken=1 and target 0x100 -> mispredict=1 and btb_wr_target=0x0000_0100.
REQ-031 SHALL cover: JALR with btb_hit=0 -> is_jmp=0, decision=1, mispredict=1.
REQ-032 SHALL cover: stall_i held for 2 cycles behind a BEQ -> two bubbles at EXMEM (all flags 0), then the BEQ emerges with its metadata intact.
REQ-033 SHALL cover: flush_i together with stall_i while 2 branches are in flight -> no valid entry reaches EXMEM for 3 cycles.
REQ-034 SHALL cover: rst_ni=0 mid-stream, and with BRU_PERF_CNT_EN defined, perf_miss_cnt_o preloaded to 0xFFFFFFFF plus one mispredict -> after reset all outputs are 0; after the mispredict the counter reads 0.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// Fetch/Execute/EX-MEM signal bundle for branch_resolve_unit.
// Perf counter ports exist only when BRU_PERF_CNT_EN is defined.
interface branch_resolve_unit_if #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8
);
  logic [31:0]                   IF_pc_i;
  logic                          IF_btb_hit_i;
  logic                          IF_prediction_i;
  logic                          IF_bias_i;
  logic [HISTORY_WIDTH-1:0]      IF_ghr_data_i;
  logic                          IF_valid_i;
  logic                          stall_i;
  logic                          flush_i;
  logic                          EX_is_br_i;
  logic                          EX_is_jal_i;
  logic                          EX_is_jalr_i;
  logic                          EX_br_taken_i;
  logic [31:0]                   EX_target_i;
  logic [INDEX_WIDTH-1:0]        EXMEM_btb_wr_index_o;
  logic [32-INDEX_WIDTH-2-1:0]   EXMEM_btb_wr_tag_o;
  logic [31:0]                   EXMEM_btb_wr_target_o;
  logic [HISTORY_WIDTH-1:0]      EXMEM_pht_wr_index_o;
  logic                          EXMEM_btb_hit_o;
  logic                          EXMEM_br_decision_o;
  logic                          EXMEM_is_jmp_o;
  logic                          EXMEM_prediction_o;
  logic                          EXMEM_bias_o;
  logic                          EXMEM_mispredict_o;
  logic [HISTORY_WIDTH-1:0]      EXMEM_ghr_data_o;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]                   perf_br_cnt_o;
  logic [31:0]                   perf_miss_cnt_o;
`endif

  modport master (
    output IF_pc_i, IF_btb_hit_i, IF_prediction_i, IF_bias_i, IF_ghr_data_i, IF_valid_i,
    output stall_i, flush_i,
    output EX_is_br_i, EX_is_jal_i, EX_is_jalr_i, EX_br_taken_i, EX_target_i,
    input  EXMEM_btb_wr_index_o, EXMEM_btb_wr_tag_o, EXMEM_btb_wr_target_o, EXMEM_pht_wr_index_o,
    input  EXMEM_btb_hit_o, EXMEM_br_decision_o, EXMEM_is_jmp_o, EXMEM_prediction_o,
    input  EXMEM_bias_o, EXMEM_mispredict_o, EXMEM_ghr_data_o
`ifdef BRU_PERF_CNT_EN
    , input perf_br_cnt_o, perf_miss_cnt_o
`endif
  );

  modport slave (
    input  IF_pc_i, IF_btb_hit_i, IF_prediction_i, IF_bias_i, IF_ghr_data_i, IF_valid_i,
    input  stall_i, flush_i,
    input  EX_is_br_i, EX_is_jal_i, EX_is_jalr_i, EX_br_taken_i, EX_target_i,
    output EXMEM_btb_wr_index_o, EXMEM_btb_wr_tag_o, EXMEM_btb_wr_target_o, EXMEM_pht_wr_index_o,
    output EXMEM_btb_hit_o, EXMEM_br_decision_o, EXMEM_is_jmp_o, EXMEM_prediction_o,
    output EXMEM_bias_o, EXMEM_mispredict_o, EXMEM_ghr_data_o
`ifdef BRU_PERF_CNT_EN
    , output perf_br_cnt_o, perf_miss_cnt_o
`endif
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries fetch-time predictor metadata IF/ID -> ID/EX -> EX/MEM and resolves branches in EX.
// Optional branch/mispredict counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int INDEX_WIDTH   = 6,
  parameter int HISTORY_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  branch_resolve_unit_if.slave bru
);
  logic                     vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic [31:2]              pc_p0_q, pc_p0_d, pc_p1_q, pc_p1_d, pc_p2_q, pc_p2_d;
  logic                     hit_p0_q, hit_p0_d, hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d;
  logic                     pred_p0_q, pred_p0_d, pred_p1_q, pred_p1_d, pred_p2_q, pred_p2_d;
  logic                     bias_p0_q, bias_p0_d, bias_p1_q, bias_p1_d, bias_p2_q, bias_p2_d;
  logic [HISTORY_WIDTH-1:0] ghr_p0_q, ghr_p0_d, ghr_p1_q, ghr_p1_d, ghr_p2_q, ghr_p2_d;
  logic                     jmp_p2_q, jmp_p2_d, dec_p2_q, dec_p2_d, mis_p2_q, mis_p2_d;
  logic [31:0]              tgt_p2_q, tgt_p2_d;
  logic                     vld_ex;
  logic                     unused_pc_lo;

  assign unused_pc_lo = ^bru.IF_pc_i[1:0];

  // IF/ID and ID/EX: flush kills both, stall holds both
  always_comb begin
    vld_p0_d  = vld_p0_q;  pc_p0_d   = pc_p0_q;   hit_p0_d = hit_p0_q;
    pred_p0_d = pred_p0_q; bias_p0_d = bias_p0_q; ghr_p0_d = ghr_p0_q;
    vld_p1_d  = vld_p1_q;  pc_p1_d   = pc_p1_q;   hit_p1_d = hit_p1_q;
    pred_p1_d = pred_p1_q; bias_p1_d = bias_p1_q; ghr_p1_d = ghr_p1_q;
    if (bru.flush_i) begin
      vld_p0_d = 1'b0;
      vld_p1_d = 1'b0;
    end else if (!bru.stall_i) begin
      vld_p0_d  = bru.IF_valid_i;      pc_p0_d   = bru.IF_pc_i[31:2];
      hit_p0_d  = bru.IF_btb_hit_i;    pred_p0_d = bru.IF_prediction_i;
      bias_p0_d = bru.IF_bias_i;       ghr_p0_d  = bru.IF_ghr_data_i;
      vld_p1_d  = vld_p0_q;  pc_p1_d   = pc_p0_q;   hit_p1_d = hit_p0_q;
      pred_p1_d = pred_p0_q; bias_p1_d = bias_p0_q; ghr_p1_d = ghr_p0_q;
    end
  end

  // EX/MEM: a stalled, flushed or invalid slot becomes an all-zero bubble
  always_comb begin
    vld_ex    = vld_p1_q & ~bru.flush_i & ~bru.stall_i;
    jmp_p2_d  = vld_ex & (bru.EX_is_br_i | bru.EX_is_jal_i);
    dec_p2_d  = vld_ex & (bru.EX_is_jal_i | bru.EX_is_jalr_i |
                          (bru.EX_is_br_i & bru.EX_br_taken_i));
    pred_p2_d = vld_ex & pred_p1_q;
    hit_p2_d  = vld_ex & hit_p1_q;
    mis_p2_d  = jmp_p2_d ? (pred_p2_d ^ dec_p2_d) : dec_p2_d;
    pc_p2_d   = vld_ex ? pc_p1_q : '0;
    bias_p2_d = vld_ex & bias_p1_q;
    ghr_p2_d  = vld_ex ? ghr_p1_q : '0;
    tgt_p2_d  = vld_ex ? bru.EX_target_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p0_q <= 1'b0; pc_p0_q <= '0; hit_p0_q <= 1'b0; pred_p0_q <= 1'b0; bias_p0_q <= 1'b0; ghr_p0_q <= '0;
      vld_p1_q <= 1'b0; pc_p1_q <= '0; hit_p1_q <= 1'b0; pred_p1_q <= 1'b0; bias_p1_q <= 1'b0; ghr_p1_q <= '0;
      pc_p2_q  <= '0;   hit_p2_q <= 1'b0; pred_p2_q <= 1'b0; bias_p2_q <= 1'b0; ghr_p2_q <= '0;
      jmp_p2_q <= 1'b0; dec_p2_q <= 1'b0; mis_p2_q <= 1'b0; tgt_p2_q <= '0;
    end else begin
      vld_p0_q <= vld_p0_d; pc_p0_q <= pc_p0_d; hit_p0_q <= hit_p0_d;
      pred_p0_q <= pred_p0_d; bias_p0_q <= bias_p0_d; ghr_p0_q <= ghr_p0_d;
      vld_p1_q <= vld_p1_d; pc_p1_q <= pc_p1_d; hit_p1_q <= hit_p1_d;
      pred_p1_q <= pred_p1_d; bias_p1_q <= bias_p1_d; ghr_p1_q <= ghr_p1_d;
      pc_p2_q  <= pc_p2_d;  hit_p2_q <= hit_p2_d; pred_p2_q <= pred_p2_d;
      bias_p2_q <= bias_p2_d; ghr_p2_q <= ghr_p2_d;
      jmp_p2_q <= jmp_p2_d; dec_p2_q <= dec_p2_d; mis_p2_q <= mis_p2_d; tgt_p2_q <= tgt_p2_d;
    end
  end

  assign bru.EXMEM_btb_wr_index_o  = pc_p2_q[INDEX_WIDTH+1:2];
  assign bru.EXMEM_btb_wr_tag_o    = pc_p2_q[31:INDEX_WIDTH+2];
  assign bru.EXMEM_pht_wr_index_o  = pc_p2_q[HISTORY_WIDTH+1:2];
  assign bru.EXMEM_btb_wr_target_o = tgt_p2_q;
  assign bru.EXMEM_btb_hit_o       = hit_p2_q;
  assign bru.EXMEM_br_decision_o   = dec_p2_q;
  assign bru.EXMEM_is_jmp_o        = jmp_p2_q;
  assign bru.EXMEM_prediction_o    = pred_p2_q;
  assign bru.EXMEM_bias_o          = bias_p2_q;
  assign bru.EXMEM_mispredict_o    = mis_p2_q;
  assign bru.EXMEM_ghr_data_o      = ghr_p2_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_br_d, perf_miss_q, perf_miss_d;

  // jmp|dec is set only for valid control-flow entries (JALR has dec without jmp)
  always_comb begin
    perf_br_d   = perf_br_q + {31'b0, jmp_p2_q | dec_p2_q};
    perf_miss_d = perf_miss_q + {31'b0, mis_p2_q};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_br_q   <= '0;
      perf_miss_q <= '0;
    end else begin
      perf_br_q   <= perf_br_d;
      perf_miss_q <= perf_miss_d;
    end
  end

  assign bru.perf_br_cnt_o   = perf_br_q;
  assign bru.perf_miss_cnt_o = perf_miss_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branch/stall/flush/reset cases plus random traffic.
module tb_branch_resolve_unit;
  localparam int IW = 6;
  localparam int HW = 8;
  localparam int TW = 32 - IW - 2;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW)) bus ();
  branch_resolve_unit #(.INDEX_WIDTH(IW), .HISTORY_WIDTH(HW)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bru   (bus)
  );

  typedef struct packed {
    logic          v;
    logic [31:0]   pc;
    logic          hit, pred, bias;
    logic [HW-1:0] ghr;
    logic          br, jal, jalr, taken;
    logic [31:0]   tgt;
  } instr_t;

  typedef struct packed {
    logic          hit, dec, jmp, pred, bias, mis;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [HW-1:0] pht, ghr;
    logic [31:0]   tgt;
  } out_t;

  typedef struct packed {
    logic full;   // all fields defined (valid entry or post-reset); else only flags are checked
    out_t o;
  } exp_t;

  exp_t        exp_q[$];
  instr_t      s_ifid, s_idex;
  out_t        last_out;
  logic [31:0] br_cnt, miss_cnt;
  int          checks = 0;
  int          errors = 0;
  int          n_mon  = 0;

  function automatic out_t resolve(input instr_t s);
    out_t o;
    logic [31:0] word;
    o      = '0;
    word   = s.pc >> 2;
    o.jmp  = s.br | s.jal;
    o.dec  = s.jal | s.jalr | (s.br & s.taken);
    o.pred = s.pred;
    o.hit  = s.hit;
    o.mis  = o.jmp ? (o.pred != o.dec) : o.dec;
    o.idx  = IW'(word % (32'd1 << IW));
    o.tag  = TW'(s.pc >> (IW + 2));
    o.pht  = HW'(word % (32'd1 << HW));
    o.tgt  = s.tgt;
    o.bias = s.bias;
    o.ghr  = s.ghr;
    return o;
  endfunction

  // kind: 0 alu, 1 br, 2 jal, 3 jalr, 4 br+jal
  function automatic instr_t mk(input logic [31:0] pc, input int kind, input logic pred,
                                input logic hit, input logic taken, input logic [31:0] tgt);
    instr_t i;
    i       = '0;
    i.v     = 1'b1;
    i.pc    = pc;
    i.pred  = pred;
    i.hit   = hit;
    i.taken = taken;
    i.tgt   = tgt;
    i.bias  = 1'($urandom);
    i.ghr   = HW'($urandom);
    i.br    = (kind == 1) || (kind == 4);
    i.jal   = (kind == 2) || (kind == 4);
    i.jalr  = (kind == 3);
    return i;
  endfunction

  function automatic instr_t idle();
    instr_t i;
    i    = mk($urandom, int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    i.v  = 1'b0;
    return i;
  endfunction

  function automatic instr_t rnd();
    return mk($urandom, int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
  endfunction

  task automatic do_cycle(input instr_t ins, input logic stall, input logic flush, input logic rstn);
    exp_t e;
    @(negedge clk);
    bus.IF_valid_i      = ins.v;
    bus.IF_pc_i         = ins.pc;
    bus.IF_btb_hit_i    = ins.hit;
    bus.IF_prediction_i = ins.pred;
    bus.IF_bias_i       = ins.bias;
    bus.IF_ghr_data_i   = ins.ghr;
    if (s_idex.v) begin
      bus.EX_is_br_i    = s_idex.br;
      bus.EX_is_jal_i   = s_idex.jal;
      bus.EX_is_jalr_i  = s_idex.jalr;
      bus.EX_br_taken_i = s_idex.taken;
      bus.EX_target_i   = s_idex.tgt;
    end else begin
      bus.EX_is_br_i    = 1'($urandom);
      bus.EX_is_jal_i   = 1'($urandom);
      bus.EX_is_jalr_i  = 1'($urandom);
      bus.EX_br_taken_i = 1'($urandom);
      bus.EX_target_i   = $urandom;
    end
    bus.stall_i = stall;
    bus.flush_i = flush;
    rst_ni      = rstn;

    // counters observe the entry currently at EX/MEM
    if (!rstn) begin
      br_cnt   = '0;
      miss_cnt = '0;
    end else begin
      br_cnt   = br_cnt + ((last_out.jmp || last_out.dec) ? 32'd1 : 32'd0);
      miss_cnt = miss_cnt + (last_out.mis ? 32'd1 : 32'd0);
    end

    e = '0;
    if (!rstn) begin
      e.full   = 1'b1;
      s_ifid.v = 1'b0;
      s_idex.v = 1'b0;
    end else if (flush) begin
      s_ifid.v = 1'b0;
      s_idex.v = 1'b0;
    end else if (!stall) begin
      if (s_idex.v) begin
        e.full = 1'b1;
        e.o    = resolve(s_idex);
      end
      s_idex = s_ifid;
      s_ifid = ins;
    end
    last_out = e.o;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    out_t act;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e        = exp_q.pop_front();
        act      = '0;
        act.hit  = bus.EXMEM_btb_hit_o;
        act.dec  = bus.EXMEM_br_decision_o;
        act.jmp  = bus.EXMEM_is_jmp_o;
        act.pred = bus.EXMEM_prediction_o;
        act.mis  = bus.EXMEM_mispredict_o;
        if (e.full) begin
          act.bias = bus.EXMEM_bias_o;
          act.idx  = bus.EXMEM_btb_wr_index_o;
          act.tag  = bus.EXMEM_btb_wr_tag_o;
          act.pht  = bus.EXMEM_pht_wr_index_o;
          act.ghr  = bus.EXMEM_ghr_data_o;
          act.tgt  = bus.EXMEM_btb_wr_target_o;
        end
        checks++;
        if (act !== e.o) begin
          errors++;
          $display("FAIL exmem_entry_%0d at %0t: got %h expected %h (hit,dec,jmp,pred,bias,mis,idx,tag,pht,ghr,tgt)",
                   n_mon, $time, act, e.o);
        end
        n_mon++;
      end
    end
  end

  initial begin : stimulus
    instr_t a;
    rst_ni = 1'b0;
    bus.IF_valid_i = 1'b0; bus.IF_pc_i = '0; bus.IF_btb_hit_i = 1'b0; bus.IF_prediction_i = 1'b0;
    bus.IF_bias_i = 1'b0; bus.IF_ghr_data_i = '0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    bus.EX_is_br_i = 1'b0; bus.EX_is_jal_i = 1'b0; bus.EX_is_jalr_i = 1'b0;
    bus.EX_br_taken_i = 1'b0; bus.EX_target_i = '0;
    s_ifid = '0; s_idex = '0; last_out = '0; br_cnt = '0; miss_cnt = '0;

    do_cycle(idle(), 1'b0, 1'b0, 1'b0);
    do_cycle(idle(), 1'b0, 1'b0, 1'b0);

    // BEQ @0x40 predicted and taken; BNE mispredicted to 0x100; JALR miss; JAL; BR+JAL
    do_cycle(mk(32'h0000_0040, 1, 1'b1, 1'b1, 1'b1, 32'h0000_0080), 1'b0, 1'b0, 1'b1);
    do_cycle(mk(32'h1234_5674, 1, 1'b0, 1'b1, 1'b1, 32'h0000_0100), 1'b0, 1'b0, 1'b1);
    do_cycle(mk(32'h0000_2008, 3, 1'b0, 1'b0, 1'b0, 32'h0000_3000), 1'b0, 1'b0, 1'b1);
    do_cycle(mk(32'hFFFF_FFFC, 2, 1'b1, 1'b1, 1'b0, 32'h0000_0004), 1'b0, 1'b0, 1'b1);
    do_cycle(mk(32'h0000_0800, 4, 1'b0, 1'b0, 1'b0, 32'h0000_0900), 1'b0, 1'b0, 1'b1);
    do_cycle(mk(32'h0000_0104, 1, 1'b1, 1'b1, 1'b0, 32'h0000_0200), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(idle(), 1'b0, 1'b0, 1'b1);

    // stall held two cycles while a BEQ sits in ID/EX
    do_cycle(mk(32'h0000_0040, 1, 1'b1, 1'b1, 1'b1, 32'h0000_00C0), 1'b0, 1'b0, 1'b1);
    do_cycle(idle(), 1'b0, 1'b0, 1'b1);
    do_cycle(rnd(), 1'b1, 1'b0, 1'b1);
    do_cycle(rnd(), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(idle(), 1'b0, 1'b0, 1'b1);

    // flush together with stall while two branches are in flight
    do_cycle(mk(32'h0000_0400, 1, 1'b0, 1'b1, 1'b1, 32'h0000_0500), 1'b0, 1'b0, 1'b1);
    do_cycle(mk(32'h0000_0404, 1, 1'b1, 1'b1, 1'b0, 32'h0000_0600), 1'b0, 1'b0, 1'b1);
    do_cycle(rnd(), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(idle(), 1'b0, 1'b0, 1'b1);

    // reset mid-stream, then immediate capture after release
    for (int i = 0; i < 3; i++) do_cycle(rnd(), 1'b0, 1'b0, 1'b1);
    do_cycle(rnd(), 1'b0, 1'b0, 1'b0);
    a = mk(32'h0000_0040, 3, 1'b1, 1'b0, 1'b0, 32'h0000_0044);
    do_cycle(a, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(idle(), 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 500; i++) begin
      do_cycle(($urandom_range(0, 3) != 0) ? rnd() : idle(),
               1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 63) != 0));
    end
    for (int i = 0; i < 4; i++) do_cycle(idle(), 1'b0, 1'b0, 1'b1);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
`ifdef BRU_PERF_CNT_EN
    checks++;
    if (bus.perf_br_cnt_o !== br_cnt) begin
      errors++;
      $display("FAIL perf_br_cnt: got %0d expected %0d", bus.perf_br_cnt_o, br_cnt);
    end
    checks++;
    if (bus.perf_miss_cnt_o !== miss_cnt) begin
      errors++;
      $display("FAIL perf_miss_cnt: got %0d expected %0d", bus.perf_miss_cnt_o, miss_cnt);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
